packet_fifo: RTL and testbench

Store-and-forward packet FIFO, next generation of the synchronous stream FIFO. Words are written speculatively and become readable only when the packet's last beat is committed. Packets longer than the memory are discarded rather than deadlocking, and an optional drop input discards flagged packets. It sits between packet producers (DMA, parsers) and consumers that must never see a partial packet.

---
 rtl/packet_fifo.sv | 126 ++++++++++++
 tb/tb_packet_fifo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_fifo.sv
// packet_fifo: store-and-forward packet FIFO; words become readable only after their packet's last beat commits.
// Optional PACKET_FIFO_DROP_EN adds receiver_drop, which discards a packet flagged on its last beat.
module packet_fifo #(
  parameter type T = logic [31:0],
  parameter int DEPTH = 32,
  parameter int RESERVED = 0,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          receiver_valid,
  output logic          receiver_ready,
  input  T              receiver_data,
  input  logic          receiver_last,
`ifdef PACKET_FIFO_DROP_EN
  input  logic          receiver_drop,
`endif
  output logic          sender_valid,
  input  logic          sender_ready,
  output T              sender_data,
  output logic          sender_last,
  output logic          available,
  output logic [CW-1:0] level,
  output logic [CW-1:0] packets,
  output logic          overflow,
  output logic          dropped
);

  localparam int AW = $clog2(DEPTH);

  // IDLE: between packets | ACTIVE: mid-packet, storing | DISCARD: swallowing an oversize packet
  typedef enum logic [1:0] {IDLE, ACTIVE, DISCARD} state_t;

  state_t          state;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   commit_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   used;
  logic [CW-1:0]   committed;
  T                mem [DEPTH];
  // Last flags live in flops so the packet count can react in the same cycle a read is issued.
  logic [DEPTH-1:0] last_mem;

  logic full;
  logic accept;
  logic write;
  logic drop_now;
  logic commit;
  logic rewind;
  logic read_data;
  logic read_last;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full           = (used == CW'(DEPTH));
  assign receiver_ready = (state == DISCARD) || !full;
  assign accept         = receiver_valid && receiver_ready;
  assign write          = accept && (state != DISCARD);
`ifdef PACKET_FIFO_DROP_EN
  assign drop_now       = write && receiver_last && receiver_drop;
`else
  assign drop_now       = 1'b0;
`endif
  assign commit         = write && receiver_last && !drop_now;
  assign rewind         = (state == ACTIVE) && full && (committed == '0);
  assign read_data      = (!sender_valid || sender_ready) && (committed != '0);
  assign read_last      = last_mem[rd_ptr];

  assign level     = committed;
  assign available = (used < CW'(DEPTH - RESERVED));

  always_ff @(posedge clock) begin
    if (write) begin
      mem[wr_ptr]      <= receiver_data;
      last_mem[wr_ptr] <= receiver_last;
    end
    if (read_data) sender_data <= mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      rd_ptr       <= '0;
      used         <= '0;
      committed    <= '0;
      packets      <= '0;
      sender_valid <= 1'b0;
      sender_last  <= 1'b0;
      overflow     <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      overflow <= rewind;
      dropped  <= drop_now;

      if (rewind || drop_now) wr_ptr <= commit_ptr;
      else if (write)         wr_ptr <= next_ptr(wr_ptr);
      if (commit)    commit_ptr <= next_ptr(wr_ptr);
      if (read_data) rd_ptr     <= next_ptr(rd_ptr);

      // A rewind never coincides with a read (committed is zero then), so subtracting is safe.
      used      <= ((rewind || drop_now) ? committed : used + CW'(write)) - CW'(read_data);
      committed <= (commit ? used + CW'(1) : committed) - CW'(read_data);
      packets   <= packets + CW'(commit) - CW'(read_data && read_last);

      if (read_data) begin
        sender_valid <= 1'b1;
        sender_last  <= read_last;
      end else if (sender_ready) begin
        sender_valid <= 1'b0;
      end

      case (state)
        IDLE:    if (accept && !receiver_last) state <= ACTIVE;
        ACTIVE:  if (rewind) state <= DISCARD;
                 else if (accept && receiver_last) state <= IDLE;
        DISCARD: if (accept && receiver_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_fifo.sv
// Directed bench for packet_fifo (DEPTH=8, RESERVED=2) with a {last,data} scoreboard checked at the sender.
module tb_packet_fifo;
  localparam int DEPTH = 8;
  localparam int RESERVED = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          receiver_valid = 1'b0;
  logic          receiver_ready;
  logic [31:0]   receiver_data = '0;
  logic          receiver_last = 1'b0;
`ifdef PACKET_FIFO_DROP_EN
  logic          receiver_drop = 1'b0;
`endif
  logic          sender_valid;
  logic          sender_ready = 1'b0;
  logic [31:0]   sender_data;
  logic          sender_last;
  logic          available;
  logic [CW-1:0] level;
  logic [CW-1:0] packets;
  logic          overflow;
  logic          dropped;

  int checks = 0;
  int failures = 0;
  int rx_cnt = 0;
  int rx_exp = 0;
  int ovf_cnt = 0;
  int drp_cnt = 0;
  int pk_max = 0;
  int gaps;
  logic track_pk = 1'b0;
  logic [32:0] sb [$];
  logic [32:0] mon_exp;

  packet_fifo #(.DEPTH(DEPTH), .RESERVED(RESERVED)) dut (
    .clock(clock),
    .reset(reset),
    .receiver_valid(receiver_valid),
    .receiver_ready(receiver_ready),
    .receiver_data(receiver_data),
    .receiver_last(receiver_last),
`ifdef PACKET_FIFO_DROP_EN
    .receiver_drop(receiver_drop),
`endif
    .sender_valid(sender_valid),
    .sender_ready(sender_ready),
    .sender_data(sender_data),
    .sender_last(sender_last),
    .available(available),
    .level(level),
    .packets(packets),
    .overflow(overflow),
    .dropped(dropped)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Drive one beat, wait for ready, and let it be accepted on the next edge.
  task automatic send_beat(input logic [31:0] d, input logic l, input logic dr, input logic keep);
    int n = 0;
    receiver_valid = 1'b1;
    receiver_data  = d;
    receiver_last  = l;
`ifdef PACKET_FIFO_DROP_EN
    receiver_drop  = dr;
`endif
    while (!receiver_ready && n < 200) begin
      step();
      n++;
    end
    checks++;
    assert (n < 200) else begin
      failures++;
      $error("FAIL send_timeout observed=%0d expected=<200 data=%0h", n, d);
    end
    if (keep && !dr) begin
      sb.push_back({l, d});
      rx_exp++;
    end
    step();
    receiver_valid = 1'b0;
    receiver_last  = 1'b0;
`ifdef PACKET_FIFO_DROP_EN
    receiver_drop  = 1'b0;
`endif
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || sender_valid) && n < 100) begin
      step();
      n++;
    end
    checks++;
    assert (n < 100) else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d expected=<100 pending=%0d", n, sb.size());
    end
  endtask

  always @(negedge clock) begin
    if (!reset && sender_valid && sender_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_underflow observed=%0h expected=empty", {sender_last, sender_data});
      end
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("rx_word", {31'd0, sender_last, sender_data}, {31'd0, mon_exp});
      end
      rx_cnt++;
    end
    if (overflow) ovf_cnt++;
    if (dropped) drp_cnt++;
    if (track_pk && int'(packets) > pk_max) pk_max = int'(packets);
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk("rst_sender_valid", sender_valid, 0);
    chk("rst_sender_last", sender_last, 0);
    chk("rst_level", level, 0);
    chk("rst_packets", packets, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_available", available, 1);
    chk("rst_receiver_ready", receiver_ready, 1);
    reset = 1'b0;
    step();

    // Commit latency and ordering of a 3-beat packet
    sender_ready = 1'b1;
    send_beat(32'hA, 1'b0, 1'b0, 1'b1);
    send_beat(32'hB, 1'b0, 1'b0, 1'b1);
    send_beat(32'hC, 1'b1, 1'b0, 1'b1);
    chk("lat_valid_e", sender_valid, 0);
    chk("commit_packets", packets, 1);
    chk("commit_level", level, 3);
    step();
    chk("lat_valid_e1", sender_valid, 1);
    drain();
    chk("drained_packets", packets, 0);
    chk("rx_cnt_pkt1", rx_cnt, 3);

    // Uncommitted words stay invisible; available tracks speculative use
    send_beat(32'h20, 1'b0, 1'b0, 1'b1);
    send_beat(32'h21, 1'b0, 1'b0, 1'b1);
    repeat (3) step();
    chk("hold_valid", sender_valid, 0);
    chk("hold_level", level, 0);
    chk("hold_avail_used2", available, 1);
    for (int i = 2; i < 5; i++) send_beat(32'h20 + i, 1'b0, 1'b0, 1'b1);
    chk("avail_used5", available, 1);
    send_beat(32'h25, 1'b0, 1'b0, 1'b1);
    chk("avail_used6", available, 0);
    chk("hold_level6", level, 0);
    send_beat(32'h26, 1'b1, 1'b0, 1'b1);
    drain();
    chk("rx_cnt_hold", rx_cnt, rx_exp);

    // Oversize packet is discarded and the following packet survives
    for (int i = 0; i < 10; i++) send_beat(32'h100 + i, (i == 9), 1'b0, 1'b0);
    chk("ovf_level", level, 0);
    chk("ovf_packets", packets, 0);
    chk("ovf_pulses", ovf_cnt, 1);
    send_beat(32'h5, 1'b1, 1'b0, 1'b1);
    drain();
    chk("ovf_pulses_after", ovf_cnt, 1);
    chk("rx_cnt_ovf", rx_cnt, rx_exp);

    // Fill with sender stalled, then drain back to back
    sender_ready = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) send_beat(32'h300 + 4 * p + i, (i == 3), 1'b0, 1'b1);
    send_beat(32'h308, 1'b1, 1'b0, 1'b1);
    chk("fill_ready", receiver_ready, 0);
    chk("fill_packets", packets, 3);
    chk("fill_level", level, 8);
    chk("fill_avail", available, 0);
    chk("fill_valid", sender_valid, 1);
    chk("fill_data_hold", sender_data, 32'h300);
    sender_ready = 1'b1;
    gaps = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      if (!sender_valid) gaps++;
    end
    chk("fill_no_gaps", gaps, 0);
    drain();
    chk("rx_cnt_fill", rx_cnt, rx_exp);

    // Flagged packet discarded (only flagged when the drop feature exists)
    track_pk = 1'b1;
    pk_max = 0;
    send_beat(32'h400, 1'b0, 1'b0, 1'b1);
`ifdef PACKET_FIFO_DROP_EN
    send_beat(32'h401, 1'b1, 1'b1, 1'b1);
`else
    send_beat(32'h401, 1'b1, 1'b0, 1'b1);
`endif
    send_beat(32'h410, 1'b0, 1'b0, 1'b1);
    send_beat(32'h411, 1'b1, 1'b0, 1'b1);
    drain();
    track_pk = 1'b0;
`ifdef PACKET_FIFO_DROP_EN
    chk("drop_pulses", drp_cnt, 1);
`else
    chk("drop_pulses", drp_cnt, 0);
`endif
    chk("drop_pk_max", pk_max, 1);
    chk("rx_cnt_drop", rx_cnt, rx_exp);

    // Reset mid-packet with committed data present
    sender_ready = 1'b0;
    send_beat(32'h500, 1'b0, 1'b0, 1'b1);
    send_beat(32'h501, 1'b1, 1'b0, 1'b1);
    send_beat(32'h510, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_packets", packets, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_sender_valid", sender_valid, 0);
    chk("mid_rst_sender_last", sender_last, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_packets", packets, 0);
    chk("mid_rst_available", available, 1);
    chk("mid_rst_ready", receiver_ready, 1);
    rx_exp -= sb.size();
    sb.delete();
    reset = 1'b0;
    sender_ready = 1'b1;
    step();
    send_beat(32'h600, 1'b0, 1'b0, 1'b1);
    send_beat(32'h601, 1'b0, 1'b0, 1'b1);
    send_beat(32'h602, 1'b1, 1'b0, 1'b1);
    drain();
    chk("rx_cnt_post_rst", rx_cnt, rx_exp);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
